// File: rtl/pwm_timebase.sv
// ============================================================================
// Module   : pwm_timebase
// Purpose  : Three-phase PWM sawtooth timebase. Duty triples are double-
//            buffered and applied only at the period boundary.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_timebase #(
  parameter int PWM_WIDTH = 16,
  parameter int PERIOD    = 4999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [PWM_WIDTH-1:0] duty_a,
  input  logic [PWM_WIDTH-1:0] duty_b,
  input  logic [PWM_WIDTH-1:0] duty_c,
  input  logic                 duty_valid,
  output logic                 duty_ready,
  output logic [PWM_WIDTH-1:0] cnt,
  output logic [PWM_WIDTH-1:0] comp_a1,
  output logic [PWM_WIDTH-1:0] comp_a2,
  output logic [PWM_WIDTH-1:0] comp_b1,
  output logic [PWM_WIDTH-1:0] comp_b2,
  output logic [PWM_WIDTH-1:0] comp_c1,
  output logic [PWM_WIDTH-1:0] comp_c2,
  output logic                 period_start,
  output logic                 center,
  output logic                 update_done
);

  localparam int                   CENTER   = PERIOD / 2;
  localparam logic [PWM_WIDTH-1:0] PERIOD_V = PWM_WIDTH'(PERIOD);
  localparam logic [PWM_WIDTH-1:0] CENTER_V = PWM_WIDTH'(CENTER);
  localparam logic [PWM_WIDTH:0]   PERIOD_X = (PWM_WIDTH+1)'(PERIOD);
  localparam logic [PWM_WIDTH:0]   CENTER_X = (PWM_WIDTH+1)'(CENTER);

  logic                 running;
  logic                 pending;
  logic [PWM_WIDTH-1:0] cnt_nxt;
  logic                 accept;
  logic                 xfer;

  logic [PWM_WIDTH-1:0] duty_in [3];
  logic [PWM_WIDTH-1:0] conv1   [3];
  logic [PWM_WIDTH-1:0] conv2   [3];
  logic [PWM_WIDTH-1:0] shd1    [3];
  logic [PWM_WIDTH-1:0] shd2    [3];
  logic [PWM_WIDTH-1:0] act1    [3];
  logic [PWM_WIDTH-1:0] act2    [3];

  assign duty_in[0] = duty_a;
  assign duty_in[1] = duty_b;
  assign duty_in[2] = duty_c;

  assign duty_ready = !pending;
  assign accept     = duty_valid && !pending;
  assign xfer       = pending && (!enable || (cnt == PERIOD_V));

  // The first enabled edge after an idle spell keeps cnt at 0 so that the
  // restarted period opens with a visible period_start cycle.
  always_comb begin
    cnt_nxt = '0;
    if (enable && running && (cnt != PERIOD_V)) begin
      cnt_nxt = cnt + PWM_WIDTH'(1);
    end
  end

  // Clamp, then split the high time around the centre; odd duties put the
  // extra count after the centre.
  always_comb begin
    logic [PWM_WIDTH:0] d;
    logic [PWM_WIDTH:0] half;
    for (int i = 0; i < 3; i++) begin
      d    = {1'b0, duty_in[i]};
      if (d > PERIOD_X) begin
        d = PERIOD_X;
      end
      half     = d >> 1;
      conv1[i] = PWM_WIDTH'(CENTER_X - half);
      conv2[i] = PWM_WIDTH'(CENTER_X + (d - half));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      running      <= 1'b0;
      pending      <= 1'b0;
      period_start <= 1'b0;
      center       <= 1'b0;
      update_done  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        shd1[i] <= CENTER_V;
        shd2[i] <= CENTER_V;
        act1[i] <= CENTER_V;
        act2[i] <= CENTER_V;
      end
    end else begin
      cnt          <= cnt_nxt;
      running      <= enable;
      period_start <= enable && (cnt_nxt == '0);
      center       <= enable && (cnt_nxt == CENTER_V);
      update_done  <= xfer;
      if (xfer) begin
        pending <= 1'b0;
      end else if (accept) begin
        pending <= 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (accept) begin
          shd1[i] <= conv1[i];
          shd2[i] <= conv2[i];
        end
        if (xfer) begin
          act1[i] <= shd1[i];
          act2[i] <= shd2[i];
        end
      end
    end
  end

  assign comp_a1 = act1[0];
  assign comp_a2 = act2[0];
  assign comp_b1 = act1[1];
  assign comp_b2 = act2[1];
  assign comp_c1 = act1[2];
  assign comp_c2 = act2[2];

endmodule

`default_nettype wire

// File: tb/tb_pwm_timebase.sv
// ============================================================================
// Module   : tb_pwm_timebase
// Purpose  : Directed self-checking bench for pwm_timebase with PERIOD=9.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_timebase;

  localparam int W = 16;
  localparam int P = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] duty_a = '0, duty_b = '0, duty_c = '0;
  logic         duty_valid = 1'b0;
  logic         duty_ready;
  logic [W-1:0] cnt;
  logic [W-1:0] comp_a1, comp_a2, comp_b1, comp_b2, comp_c1, comp_c2;
  logic         period_start, center, update_done;

  int vectors = 0;
  int miscompares = 0;
  int hi_a, hi_c;

  pwm_timebase #(.PWM_WIDTH(W), .PERIOD(P)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .cnt(cnt),
    .comp_a1(comp_a1), .comp_a2(comp_a2), .comp_b1(comp_b1),
    .comp_b2(comp_b2), .comp_c1(comp_c1), .comp_c2(comp_c2),
    .period_start(period_start), .center(center), .update_done(update_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_comps(input string tag, input int a1, input int a2, input int b1,
                           input int b2, input int c1, input int c2);
    chk({tag, "_a1"}, 32'(comp_a1), 32'(a1));
    chk({tag, "_a2"}, 32'(comp_a2), 32'(a2));
    chk({tag, "_b1"}, 32'(comp_b1), 32'(b1));
    chk({tag, "_b2"}, 32'(comp_b2), 32'(b2));
    chk({tag, "_c1"}, 32'(comp_c1), 32'(c1));
    chk({tag, "_c2"}, 32'(comp_c2), 32'(c2));
  endtask

  task automatic drive(input int a, input int b, input int c);
    duty_a     = W'(a);
    duty_b     = W'(b);
    duty_c     = W'(c);
    duty_valid = 1'b1;
  endtask

  initial begin
    // Reset state
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_cnt", 32'(cnt), 0);
    chk_comps("rst", 4, 4, 4, 4, 4, 4);
    chk("rst_ready", 32'(duty_ready), 1);
    chk("rst_pstart", 32'(period_start), 0);
    chk("rst_center", 32'(center), 0);
    chk("rst_upd", 32'(update_done), 0);

    // Counting: restart cycle at 0, centre at 4, wrap after 9
    enable = 1'b1;
    step(1);
    chk("cnt_start", 32'(cnt), 0);
    chk("pstart_first", 32'(period_start), 1);
    step(4);
    chk("cnt_4", 32'(cnt), 4);
    chk("center_4", 32'(center), 1);
    chk("pstart_4", 32'(period_start), 0);
    step(1);
    chk("center_5", 32'(center), 0);
    step(4);
    chk("cnt_9", 32'(cnt), 9);
    step(1);
    chk("cnt_wrap", 32'(cnt), 0);
    chk("pstart_wrap", 32'(period_start), 1);

    // Conversion: accept at cnt=0, applied at the next wrap
    drive(4, 5, 0);
    step(1);
    duty_valid = 1'b0;
    chk("conv_cnt1", 32'(cnt), 1);
    chk("conv_ready_low", 32'(duty_ready), 0);
    step(8);
    chk("conv_hold_a1", 32'(comp_a1), 4);
    step(1);
    chk("conv_cnt0", 32'(cnt), 0);
    chk_comps("conv", 2, 6, 2, 7, 4, 4);
    chk("conv_upd", 32'(update_done), 1);
    chk("conv_ready", 32'(duty_ready), 1);
    chk("conv_pstart", 32'(period_start), 1);
    step(1);
    chk("conv_upd_off", 32'(update_done), 0);

    // Clamp + accept at cnt=PERIOD: transfer waits a full period
    step(8);
    chk("hs_cnt9", 32'(cnt), 9);
    drive(20, 9, 1);
    step(1);
    chk("hs_ready_low", 32'(duty_ready), 0);
    chk("hs_no_upd", 32'(update_done), 0);
    chk("hs_keep_a1", 32'(comp_a1), 2);
    drive(3, 3, 3);
    step(9);
    chk("hs_ready_still", 32'(duty_ready), 0);
    step(1);
    duty_valid = 1'b0;
    chk("hs_cnt0", 32'(cnt), 0);
    chk_comps("clamp", 0, 9, 0, 9, 4, 5);
    chk("hs_upd", 32'(update_done), 1);
    hi_a = 0;
    hi_c = 0;
    for (int k = 0; k < 10; k++) begin
      if ((cnt <= comp_a1) ^ (cnt <= comp_a2)) hi_a++;
      if ((cnt <= comp_c1) ^ (cnt <= comp_c2)) hi_c++;
      step(1);
    end
    chk("pwm_high_a", 32'(hi_a), 9);
    chk("pwm_high_c", 32'(hi_c), 1);
    chk("second_ignored_a1", 32'(comp_a1), 0);
    chk("second_ignored_b2", 32'(comp_b2), 9);
    chk("hs_ready_back", 32'(duty_ready), 1);

    // Enable gating: counter held, immediate transfer two clocks after accept
    step(3);
    chk("gate_cnt3", 32'(cnt), 3);
    enable = 1'b0;
    step(1);
    chk("gate_cnt0", 32'(cnt), 0);
    chk("gate_keep_a1", 32'(comp_a1), 0);
    step(2);
    chk("gate_hold", 32'(cnt), 0);
    chk("gate_no_pstart", 32'(period_start), 0);
    drive(6, 2, 9);
    step(1);
    duty_valid = 1'b0;
    chk("gate_ready_low", 32'(duty_ready), 0);
    chk("gate_pre_a1", 32'(comp_a1), 0);
    step(1);
    chk_comps("gate", 1, 7, 3, 5, 0, 9);
    chk("gate_upd", 32'(update_done), 1);
    chk("gate_cnt_held", 32'(cnt), 0);
    enable = 1'b1;
    step(1);
    chk("reen_cnt", 32'(cnt), 0);
    chk("reen_pstart", 32'(period_start), 1);
    step(1);
    chk("reen_cnt1", 32'(cnt), 1);

    // Asynchronous reset mid-count with a pending shadow
    step(3);
    chk("pre_rst_center", 32'(center), 1);
    drive(8, 8, 8);
    step(1);
    duty_valid = 1'b0;
    chk("pre_rst_ready", 32'(duty_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(cnt), 0);
    chk_comps("arst", 4, 4, 4, 4, 4, 4);
    chk("arst_ready", 32'(duty_ready), 1);
    step(1);
    rst = 1'b0;
    enable = 1'b0;
    step(2);
    chk("post_rst_a1", 32'(comp_a1), 4);
    chk("post_rst_upd", 32'(update_done), 0);
    chk("post_rst_ready", 32'(duty_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_timebase.md
# pwm_timebase

Three-phase PWM timebase and compare generator for the motor-drive path. It produces the shared sawtooth counter `cnt` and, for each phase, the `comp1`/`comp2` pair consumed by the per-phase dead-time PWM stage. That stage drives the gate high while `(cnt <= comp1) ^ (cnt <= comp2)`. Duty commands arrive from the modulator (SVPWM/Clarke path) through a valid/ready handshake. They are double-buffered and applied only at the period boundary, so a period never contains a torn compare pair.

## Interface
- `PWM_WIDTH`, 16: width of the counter, compares and duty inputs.
- `PERIOD`, 4999: terminal count. The counter runs 0..PERIOD, so one period is PERIOD+1 clocks. Legal range is 2 ≤ PERIOD ≤ 2^PWM_WIDTH−2.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `enable`  in  1: run the counter when 1; hold it at 0 when 0.
- `duty_a`, `duty_b`, `duty_c`  in  PWM_WIDTH each: requested high-time per phase, in counts.
- `duty_valid`  in  1: duty triple is valid.
- `duty_ready`  out  1: block can accept a triple.
- `cnt`  out  PWM_WIDTH: shared sawtooth counter.
- `comp_a1`, `comp_a2`, `comp_b1`, `comp_b2`, `comp_c1`, `comp_c2`  out  PWM_WIDTH each: active compare pairs.
- `period_start`  out  1: one-cycle pulse while `cnt == 0` and enabled.
- `center`  out  1: one-cycle pulse while `cnt == C` and enabled (ADC sample trigger).
- `update_done`  out  1: one-cycle pulse in the cycle after a shadow→active transfer.

## Operation
- Constant C = floor(PERIOD/2), the pulse centre.
- **Counter:**
  - `enable=1`: `cnt` increments by 1 per clock; PERIOD wraps to 0.
  - `enable=0`: `cnt` is forced to 0 on the next edge and held.
  - Re-enabling starts counting from 0; the first enabled cycle at 0 raises `period_start`.
- **Duty conversion**, performed at accept, per phase:
  - d = min(duty, PERIOD); values above PERIOD clamp to PERIOD.
  - shadow c1 = C − floor(d/2); shadow c2 = C + ceil(d/2).
  - Computed at PWM_WIDTH+1 bits internally; no wrap is possible after the clamp.
  - Resulting high time is exactly d counts per period, centred on C.
  - d=0 gives c1=c2=C (output never high). d=PERIOD gives c1=0, c2=PERIOD (low only at cnt=0).
- **Handshake:**
  - `duty_ready = !pending`.
  - A transfer happens on an edge where `duty_valid && duty_ready`. On that edge the shadow registers load all three phases and `pending` sets.
  - `duty_valid` while not ready is ignored; nothing is queued.
  - Inputs need only be stable in the accept cycle.
- **Shadow→active transfer:**
  - With `enable=1`, the transfer happens on the edge where `cnt == PERIOD && pending`. The active compares therefore change together with `cnt` wrapping to 0, and `pending` clears.
  - With `enable=0`, the transfer happens on the first edge with `pending=1`; the immediate load prepares the first period.
- **Boundary conditions:**
  - Accept in the cycle where `cnt == PERIOD`: `pending` is not yet set on that edge, so the transfer waits one full period.
  - Only one triple is buffered. A second triple is stalled (ready=0) until the transfer completes.
  - `enable` falling mid-period: `cnt` goes to 0 and the active compares are kept. A pending shadow transfers on the following edge.
  - Reset asserted mid-operation: all state returns to reset values immediately. Any pending shadow is discarded.

## Timing
- **Reset values:**
  - `cnt` = 0.
  - All active and shadow compares = C, so every phase outputs zero duty.
  - `pending` = 0, so `duty_ready` = 1.
  - `period_start`, `center`, `update_done` = 0.
- All outputs except `duty_ready` are registered. `duty_ready` is combinational from the `pending` flop.
- Accept edge → `duty_ready` low from the next cycle.
- Accept→active latency: 2 to PERIOD+2 clocks, depending on the counter phase.
- `update_done`, `period_start` and the new `ready=1` all appear in the same cycle: the first cycle with `cnt == 0` and the new compares.
- `period_start` and `center` are registered decodes, each aligned with the corresponding `cnt` value.
- Throughput: at most one duty triple per period.

## Test plan
- **Reset:** assert `rst` mid-count with PERIOD=9 → outputs go to cnt=0, all comps=4, ready=1 asynchronously, with no clock edge required.
- **Counting:** PERIOD=9, enable=1 → cnt sequence 0..9,0. `period_start` is high at cnt=0 and `center` at cnt=4, once per 10 clocks.
- **Conversion:** PERIOD=9, accept duty_a=4, duty_b=5, duty_c=0 → after the wrap: a=(2,6), b=(2,7), c=(4,4). `update_done` is high at cnt=0.
- **Clamp:** PERIOD=9, duty_a=20 → after the wrap, comp_a=(0,9). Checking a 9/10 duty with the PWM model confirms it.
- **Handshake:** accept at cnt=9 → ready stays low and the transfer occurs at the next wrap (11 clocks later). A second valid while pending is ignored, and its values never appear.
- **Enable gating:** enable=0 with one accept → comps update 2 clocks after the accept and cnt stays 0. Raising enable gives a `period_start` pulse at cnt=0.
